// File: rtl/popcount_select_32bit_pkg.sv
// Shared constants and FSM encoding for the 32-bit select (k-th set bit) unit.
package popcount_select_32bit_pkg;
    localparam int WIDTH  = 32;
    localparam int LANE   = 8;
    localparam int NLANES = WIDTH / LANE;
    localparam int IDXW   = 5;
    localparam int KW     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/popcount_select_32bit_lane.sv
// One scan lane: popcount of the lane bits plus the offset of the rank-th set bit.
module lane_select8
    import popcount_select_32bit_pkg::*;
#(
    parameter int LW = LANE,
    parameter int RW = KW
) (
    input  logic [LW-1:0]           bits,
    input  logic [RW-1:0]           rank,
    output logic [$clog2(LW+1)-1:0] cnt,
    output logic [$clog2(LW)-1:0]   offset,
    output logic                    hit
);
    localparam int CW = $clog2(LW + 1);
    localparam int OW = $clog2(LW);

    logic [RW-1:0] pre;

    // Running prefix count; only the bit that brings the prefix up to rank matches.
    always_comb begin
        pre    = '0;
        offset = '0;
        for (int i = 0; i < LW; i++) begin
            if (bits[i]) begin
                pre = pre + 1'b1;
                if (pre == rank) offset = OW'(i);
            end
        end
        cnt = CW'(pre);
        hit = (rank != '0) && (rank <= pre);
    end
endmodule

// File: rtl/popcount_select_32bit.sv
// Select unit: index of the k-th set bit (1-based, from bit 0), one lane per cycle.
module popcount_select_32bit #(
    parameter int WIDTH = popcount_select_32bit_pkg::WIDTH,
    parameter int LANE  = popcount_select_32bit_pkg::LANE,
    parameter int IDXW  = popcount_select_32bit_pkg::IDXW,
    parameter int KW    = popcount_select_32bit_pkg::KW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s_in,
    input  logic [KW-1:0]    k_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  idx_out,
    output logic             found_out,
    output logic [KW-1:0]    cnt_out
);
    import popcount_select_32bit_pkg::state_t;
    import popcount_select_32bit_pkg::IDLE;
    import popcount_select_32bit_pkg::SCAN;
    import popcount_select_32bit_pkg::DONE;

    localparam int NLANES = WIDTH / LANE;
    localparam int LNW    = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int CW     = $clog2(LANE + 1);
    localparam int OW     = $clog2(LANE);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] word;
    logic [KW-1:0]    rem, acc;
    logic [LNW-1:0]   lane;

    logic [LANE-1:0]  lane_bits;
    logic [CW-1:0]    lane_cnt;
    logic [OW-1:0]    lane_off;
    logic             lane_hit;
    logic             last_lane;
    logic [IDXW-1:0]  hit_idx;
    logic [KW-1:0]    acc_sum;

    assign lane_bits = word[int'(lane)*LANE +: LANE];
    assign last_lane = (lane == LNW'(NLANES - 1));
    assign hit_idx   = IDXW'(int'(lane) * LANE + int'(lane_off));
    assign acc_sum   = acc + KW'(lane_cnt);

    lane_select8 #(.LW(LANE), .RW(KW)) u_lane (
        .bits   (lane_bits),
        .rank   (rem),
        .cnt    (lane_cnt),
        .offset (lane_off),
        .hit    (lane_hit)
    );

    assign in_ready  = enable && (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (k_in == '0) ? DONE : SCAN;
            SCAN: if (lane_hit || last_lane) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All state advances only under enable, so a low enable freezes the unit mid-flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word      <= '0;
            rem       <= '0;
            acc       <= '0;
            lane      <= '0;
            idx_out   <= '0;
            found_out <= 1'b0;
            cnt_out   <= '0;
        end else if (enable) begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    word      <= s_in;
                    rem       <= k_in;
                    acc       <= '0;
                    lane      <= '0;
                    idx_out   <= '0;
                    found_out <= 1'b0;
                    cnt_out   <= '0;
                end
                SCAN: begin
                    if (lane_hit) begin
                        idx_out   <= hit_idx;
                        found_out <= 1'b1;
                        cnt_out   <= acc_sum;
                    end else begin
                        rem  <= rem - KW'(lane_cnt);
                        acc  <= acc_sum;
                        lane <= lane + 1'b1;
                        if (last_lane) begin
                            idx_out   <= '0;
                            found_out <= 1'b0;
                            cnt_out   <= acc_sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_select_32bit.sv
// Directed vector table plus hand sequences for backpressure, enable stall and reset.
module tb_popcount_select_32bit;
    logic        clk = 1'b0;
    logic        rst, enable, in_valid, in_ready, out_valid, out_ready, found_out;
    logic [31:0] s_in;
    logic [5:0]  k_in, cnt_out;
    logic [4:0]  idx_out;

    int n_chk  = 0;
    int n_fail = 0;

    popcount_select_32bit dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .s_in(s_in), .k_in(k_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .idx_out(idx_out), .found_out(found_out), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [5:0]  k;
        logic [4:0]  idx;
        logic        found;
        logic [5:0]  cnt;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request, optionally stall enable right after accept, and drain the result.
    task automatic do_req(input logic [31:0] s, input logic [5:0] k, input int stall,
                          output int lat, output logic [4:0] idx, output logic f,
                          output logic [5:0] cnt);
        in_valid = 1'b1; s_in = s; k_in = k;
        @(posedge clk); #1;
        in_valid = 1'b0; s_in = $urandom; k_in = 6'($urandom);
        lat = 1;
        if (stall > 0) begin
            enable = 1'b0;
            repeat (stall) begin
                @(posedge clk); #1;
                lat++;
                chk("stall_in_ready", int'(in_ready), 0);
            end
            enable = 1'b1;
        end
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        idx = idx_out; f = found_out; cnt = cnt_out;
        chk("done_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        logic [4:0] idx, idx0;
        logic       f;
        logic [5:0] cnt, cnt0;

        vecs[0]  = '{32'h0000_0001, 6'd1,  5'd0,  1'b1, 6'd1,  2};
        vecs[1]  = '{32'h8000_0000, 6'd1,  5'd31, 1'b1, 6'd1,  5};
        vecs[2]  = '{32'hFFFF_FFFF, 6'd17, 5'd16, 1'b1, 6'd24, 4};
        vecs[3]  = '{32'hFFFF_FFFF, 6'd32, 5'd31, 1'b1, 6'd32, 5};
        vecs[4]  = '{32'h0F0F_0F0F, 6'd9,  5'd16, 1'b1, 6'd12, 4};
        vecs[5]  = '{32'h0F0F_0F0F, 6'd17, 5'd0,  1'b0, 6'd16, 5};
        vecs[6]  = '{32'h0F0F_0F0F, 6'd0,  5'd0,  1'b0, 6'd0,  1};
        vecs[7]  = '{32'hFFFF_FFFF, 6'd33, 5'd0,  1'b0, 6'd32, 5};
        vecs[8]  = '{32'h0000_0000, 6'd1,  5'd0,  1'b0, 6'd0,  5};
        vecs[9]  = '{32'h0000_0100, 6'd1,  5'd8,  1'b1, 6'd1,  3};
        vecs[10] = '{32'h0000_00A5, 6'd3,  5'd5,  1'b1, 6'd4,  2};
        vecs[11] = '{32'hFFFF_FFFF, 6'd1,  5'd0,  1'b1, 6'd8,  2};

        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        s_in = '0; k_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_idx", int'(idx_out), 0);
        chk("rst_found", int'(found_out), 0);
        chk("rst_cnt", int'(cnt_out), 0);

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].s, vecs[i].k, 0, lat, idx, f, cnt);
            chk($sformatf("v%0d_idx", i), int'(idx), int'(vecs[i].idx));
            chk($sformatf("v%0d_found", i), int'(f), int'(vecs[i].found));
            chk($sformatf("v%0d_cnt", i), int'(cnt), int'(vecs[i].cnt));
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
        end

        // Enable low for 2 cycles in SCAN: same result, latency +2.
        do_req(32'hFFFF_FFFF, 6'd17, 2, lat, idx, f, cnt);
        chk("stall_idx", int'(idx), 16);
        chk("stall_cnt", int'(cnt), 24);
        chk("stall_lat", lat, 6);

        // Backpressure: hold out_ready low for 3 cycles in DONE.
        in_valid = 1'b1; s_in = 32'h0000_0100; k_in = 6'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", lat, 3);
        idx0 = idx_out; cnt0 = cnt_out;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_idx", int'(idx_out), 8);
            chk("bp_cnt", int'(cnt_out), 1);
        end
        chk("bp_idx_hold", int'(idx0), 8);
        chk("bp_cnt_hold", int'(cnt0), 1);
        // enable low while DONE: out_ready ignored.
        enable = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("en_off_out_valid", int'(out_valid), 1);
        enable = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_rel_out_valid", int'(out_valid), 0);
        chk("bp_rel_in_ready", int'(in_ready), 1);

        // Reset mid-SCAN.
        in_valid = 1'b1; s_in = 32'hFFFF_FFFF; k_in = 6'd32;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_in_ready", int'(in_ready), 1);
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_idx", int'(idx_out), 0);
        chk("mrst_cnt", int'(cnt_out), 0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("mrst_stays_idle", int'(out_valid), 0);
        end

        // Reset while a nonzero result is held in DONE.
        in_valid = 1'b1; s_in = 32'h8000_0000; k_in = 6'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("drst_pre_idx", int'(idx_out), 31);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("drst_out_valid", int'(out_valid), 0);
        chk("drst_idx", int'(idx_out), 0);
        chk("drst_found", int'(found_out), 0);
        chk("drst_cnt", int'(cnt_out), 0);
        chk("drst_in_ready", int'(in_ready), 1);

        // Unit still works after reset.
        do_req(32'h0000_00A5, 6'd4, 0, lat, idx, f, cnt);
        chk("post_idx", int'(idx), 7);
        chk("post_found", int'(f), 1);
        chk("post_lat", lat, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
